// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one pipelined 32-bit divider among NUM_REQ requesters.
// Each accepted request pushes its requester index into an in-order tag FIFO; each divider
// result pops the head tag and is steered back to that requester.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   req_valid/req_ready             per-requester handshake (req_ready is combinational one-hot)
//   req_dividend/req_divisor        packed operands, requester i at [32i+31:32i]
//   div_start/div_dividend/div_divisor   registered issue to the divider
//   div_ready/div_quotient/div_remainder result pulse and data from the divider
//   rsp_valid/rsp_quotient/rsp_remainder one-hot result pulse and shared result buses
//   busy                            divisions outstanding
//   err_unexpected                  sticky: divider result arrived with nothing outstanding
module divider_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TAG_W           = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_dividend,
    input  logic [32*NUM_REQ-1:0] req_divisor,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  div_start,
    output logic [31:0]           div_dividend,
    output logic [31:0]           div_divisor,
    input  logic                  div_ready,
    input  logic [31:0]           div_quotient,
    input  logic [31:0]           div_remainder,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_quotient,
    output logic [31:0]           rsp_remainder,
    output logic                  busy,
    output logic                  err_unexpected
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TAG_W-1:0]   tag_mem [MAX_OUTSTANDING];

    logic               can_issue, push, pop;
    logic               grant_valid;
    logic [TAG_W-1:0]   grant_idx;
    logic [TAG_W:0]     scan_idx;
    logic [31:0]        sel_dividend, sel_divisor;

    logic               div_start_q;
    logic [31:0]        div_dividend_q, div_divisor_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [31:0]        rsp_quotient_q, rsp_remainder_q;
    logic               busy_q, err_q;

    // A result popping this cycle frees a slot for a same-cycle issue.
    assign can_issue = (count_q < CNT_W'(MAX_OUTSTANDING)) || div_ready;
    assign pop       = div_ready && (count_q != '0);
    assign push      = grant_valid;

    // Round-robin search starting at rr_ptr_q; scan_idx is one bit wider to absorb the wrap.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        if (!rst && can_issue) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                scan_idx = {1'b0, rr_ptr_q} + (TAG_W+1)'(k);
                if (scan_idx >= (TAG_W+1)'(NUM_REQ)) begin
                    scan_idx = scan_idx - (TAG_W+1)'(NUM_REQ);
                end
                if (!grant_valid && ((req_valid & (NUM_REQ'(1) << scan_idx)) != '0)) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan_idx[TAG_W-1:0];
                end
            end
        end
    end

    assign req_ready = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == TAG_W'(i)) begin
                sel_dividend = req_dividend[i*32 +: 32];
                sel_divisor  = req_divisor[i*32 +: 32];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Tag storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            div_start_q     <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            rsp_valid_q     <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            busy_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            count_q     <= count_d;
            busy_q      <= (count_d != '0);
            div_start_q <= push;
            if (push) begin
                wr_ptr_q       <= wr_ptr_q + PTR_W'(1);
                div_dividend_q <= sel_dividend;
                div_divisor_q  <= sel_divisor;
            end
            if (pop) begin
                rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
                rsp_valid_q     <= NUM_REQ'(1) << tag_mem[rd_ptr_q];
                rsp_quotient_q  <= div_quotient;
                rsp_remainder_q <= div_remainder;
            end else begin
                rsp_valid_q <= '0;
            end
            if (div_ready && (count_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign div_start      = div_start_q;
    assign div_dividend   = div_dividend_q;
    assign div_divisor    = div_divisor_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_quotient   = rsp_quotient_q;
    assign rsp_remainder  = rsp_remainder_q;
    assign busy           = busy_q;
    assign err_unexpected = err_q;

endmodule
